// File: rtl/beat_sequencer.sv
// Tempo-driven note recorder/player: records note_in on each beat into a small
// memory and plays it back on later beats, with an optional wrap-around loop.
module beat_sequencer #(
  parameter int CLK_HZ  = 50000000,
  parameter int DATA_W  = 10,
  parameter int ADDR_W  = 6,
  parameter int LED_CYC = 10000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              select,
  input  logic              back,
  input  logic [1:0]        mode,
  input  logic [2:0]        speed,
  input  logic              loop,
  input  logic [DATA_W-1:0] note_in,
  output logic [DATA_W-1:0] note_out,
  output logic              note_valid,
  output logic              beat,
  output logic              beat_led,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   length,
  output logic              full,
  output logic [2:0]        state
);

  localparam int          DEPTH = 1 << ADDR_W;
  localparam logic [63:0] HZ60  = 64'(CLK_HZ) * 64'd60;
  localparam int          CNT_W = $clog2(HZ60 / 64'd40 + 64'd1);
  localparam int          LED_W = $clog2(LED_CYC + 1);

  // Beat periods folded to constants so no divider is built.
  localparam logic [63:0] P0 = HZ60 / 64'd40;
  localparam logic [63:0] P1 = HZ60 / 64'd60;
  localparam logic [63:0] P2 = HZ60 / 64'd80;
  localparam logic [63:0] P3 = HZ60 / 64'd100;
  localparam logic [63:0] P4 = HZ60 / 64'd120;
  localparam logic [63:0] P5 = HZ60 / 64'd140;
  localparam logic [63:0] P6 = HZ60 / 64'd180;
  localparam logic [63:0] P7 = HZ60 / 64'd220;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REC_ARM   = 3'd1,
    RECORDING = 3'd2,
    PLAYING   = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t             state_q, state_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [ADDR_W:0]    len_n;
  logic               wr_en, rd_en, play_end, play_end_n;
  logic               sel_q, back_q, sel_p, back_p;
  logic [CNT_W-1:0]   cnt;
  logic [LED_W-1:0]   led_cnt;
  logic               active;
  logic [DATA_W-1:0]  mem [DEPTH];

  function automatic logic [CNT_W-1:0] period_m1(input logic [2:0] s);
    case (s)
      3'd0:    return CNT_W'(P0 - 64'd1);
      3'd1:    return CNT_W'(P1 - 64'd1);
      3'd2:    return CNT_W'(P2 - 64'd1);
      3'd3:    return CNT_W'(P3 - 64'd1);
      3'd4:    return CNT_W'(P4 - 64'd1);
      3'd5:    return CNT_W'(P5 - 64'd1);
      3'd6:    return CNT_W'(P6 - 64'd1);
      default: return CNT_W'(P7 - 64'd1);
    endcase
  endfunction

  assign sel_p    = select & ~sel_q;
  assign back_p   = back & ~back_q;
  assign active   = (state_q == RECORDING) || (state_q == PLAYING);
  assign beat     = active && (cnt == '0);
  assign beat_led = beat || (led_cnt != '0);
  assign full     = (length == (ADDR_W+1)'(DEPTH));
  assign state    = state_q;

  always_comb begin
    state_n    = state_q;
    addr_n     = addr;
    len_n      = length;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    play_end_n = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_p && !back_p) begin
          if (mode == 2'd0) state_n = REC_ARM;
          else if (mode == 2'd1) begin
            state_n = PLAYING;
            addr_n  = '0;
          end
        end
      end
      REC_ARM: begin
        if (back_p) state_n = IDLE;
        else if (sel_p) begin
          state_n = RECORDING;
          addr_n  = '0;
          len_n   = '0;
        end
      end
      RECORDING: begin
        // Beat write lands first; a coincident press then overrides state/length.
        if (beat) begin
          wr_en  = 1'b1;
          addr_n = addr + 1'b1;
          len_n  = {1'b0, addr} + 1'b1;
          if (addr == ADDR_W'(DEPTH - 1)) state_n = DONE;
        end
        if (back_p) begin
          state_n = REC_ARM;
          len_n   = '0;
        end else if (sel_p) state_n = DONE;
      end
      PLAYING: begin
        if (back_p) state_n = IDLE;
        else if (sel_p || length == '0 || play_end) state_n = DONE;
        else if (beat) begin
          rd_en = 1'b1;
          if ({1'b0, addr} + 1'b1 == length) begin
            if (loop) addr_n = '0;
            else play_end_n = 1'b1;
          end else addr_n = addr + 1'b1;
        end
      end
      DONE: if (sel_p || back_p) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      addr       <= '0;
      length     <= '0;
      note_out   <= '0;
      note_valid <= 1'b0;
      play_end   <= 1'b0;
      sel_q      <= 1'b0;
      back_q     <= 1'b0;
      led_cnt    <= '0;
    end else begin
      state_q    <= state_n;
      addr       <= addr_n;
      length     <= len_n;
      note_valid <= rd_en;
      play_end   <= play_end_n;
      sel_q      <= select;
      back_q     <= back;
      if (rd_en) note_out <= mem[addr];
      if (beat) led_cnt <= LED_W'(LED_CYC - 1);
      else if (led_cnt != '0) led_cnt <= led_cnt - 1'b1;
    end
  end

  // Outside the two running states the counter sits at a full period.
  always_ff @(posedge clk) begin
    if (!resetn || !active || beat) cnt <= period_m1(speed);
    else cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (resetn && wr_en) mem[addr] <= note_in;
  end

endmodule
